// File: rtl/ibex_multdiv_issue_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ibex_multdiv_issue_if : request / unit / writeback signals of the issuer |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface ibex_multdiv_issue_if;
   // decoder request
   logic             req_valid_i;
   logic             req_ready_o;
   logic [1:0]       req_op_i;
   logic [1:0]       req_signed_i;
   logic [31:0]      req_op_a_i;
   logic [31:0]      req_op_b_i;
   logic [4:0]       req_rd_i;
   logic             kill_i;
   // multiplier/divider unit
   logic             mult_en_o;
   logic             div_en_o;
   logic             mult_sel_o;
   logic             div_sel_o;
   logic [1:0]       operator_o;
   logic [1:0]       signed_mode_o;
   logic [31:0]      op_a_o;
   logic [31:0]      op_b_o;
   logic             data_ind_timing_o;
   logic             multdiv_ready_id_o;
   logic             valid_i;
   logic [31:0]      result_i;
   logic [1:0][33:0] imd_val_d_i;
   logic [1:0]       imd_val_we_i;
   logic [1:0][33:0] imd_val_q_o;
   // writeback buffer
   logic             wb_valid_o;
   logic             wb_ready_i;
   logic [4:0]       wb_rd_o;
   logic [31:0]      wb_data_o;

   modport master (
      input  req_valid_i, req_op_i, req_signed_i, req_op_a_i, req_op_b_i, req_rd_i, kill_i,
      input  valid_i, result_i, imd_val_d_i, imd_val_we_i, wb_ready_i,
      output req_ready_o, mult_en_o, div_en_o, mult_sel_o, div_sel_o, operator_o,
      output signed_mode_o, op_a_o, op_b_o, data_ind_timing_o, multdiv_ready_id_o,
      output imd_val_q_o, wb_valid_o, wb_rd_o, wb_data_o
   );

   modport slave (
      output req_valid_i, req_op_i, req_signed_i, req_op_a_i, req_op_b_i, req_rd_i, kill_i,
      output valid_i, result_i, imd_val_d_i, imd_val_we_i, wb_ready_i,
      input  req_ready_o, mult_en_o, div_en_o, mult_sel_o, div_sel_o, operator_o,
      input  signed_mode_o, op_a_o, op_b_o, data_ind_timing_o, multdiv_ready_id_o,
      input  imd_val_q_o, wb_valid_o, wb_rd_o, wb_data_o
   );
endinterface
`default_nettype wire

// File: rtl/ibex_multdiv_issue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ibex_multdiv_issue : issues one MUL/DIV to the slow unit, buffers result |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ibex_multdiv_issue #(
   parameter logic DataIndTiming = 1'b0
) (
   input  logic                 clk_int,
   input  logic                 rst_ni,
   ibex_multdiv_issue_if.master bus
);

   localparam logic [1:0] MD_OP_MULL = 2'd0;
   localparam logic [1:0] MD_OP_MULH = 2'd1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      DRAIN = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [1:0]       op_q;
   logic [1:0]       signed_q;
   logic [31:0]      op_a_q;
   logic [31:0]      op_b_q;
   logic [4:0]       rd_q;
   logic [1:0][33:0] imd_q;
   logic             wb_valid_q;
   logic [31:0]      wb_data_q;
   logic [4:0]       wb_rd_q;

   logic             req_ready;
   logic             accept;
   logic             run;
   logic             ready_id;
   logic             capture;
   logic             is_mul;

   assign is_mul = (op_q == MD_OP_MULL) || (op_q == MD_OP_MULH);

   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      accept    = 1'b0;
      run       = 1'b0;
      ready_id  = 1'b0;
      capture   = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = rst_ni & ~bus.kill_i;
            accept    = bus.req_valid_i & req_ready;
            if (accept) state_d = BUSY;
         end
         BUSY: begin
            run      = 1'b1;
            ready_id = bus.kill_i | ~wb_valid_q | bus.wb_ready_i;
            if (bus.valid_i) begin
               // a killed result is acknowledged to the unit but never buffered
               if (bus.kill_i) begin
                  state_d = IDLE;
               end else if (ready_id) begin
                  capture = 1'b1;
                  state_d = IDLE;
               end
            end else if (bus.kill_i) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            // the unit only resets its sequencing on completion, so keep it running
            run      = 1'b1;
            ready_id = 1'b1;
            if (bus.valid_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_int or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_ff @(posedge clk_int or negedge rst_ni) begin
      if (!rst_ni) begin
         op_q     <= 2'd0;
         signed_q <= 2'd0;
         op_a_q   <= 32'd0;
         op_b_q   <= 32'd0;
         rd_q     <= 5'd0;
      end else if (accept) begin
         op_q     <= bus.req_op_i;
         signed_q <= bus.req_signed_i;
         op_a_q   <= bus.req_op_a_i;
         op_b_q   <= bus.req_op_b_i;
         rd_q     <= bus.req_rd_i;
      end
   end

   // a capture in the same cycle as a consume wins, keeping the buffer full
   always_ff @(posedge clk_int or negedge rst_ni) begin
      if (!rst_ni) begin
         wb_valid_q <= 1'b0;
         wb_data_q  <= 32'd0;
         wb_rd_q    <= 5'd0;
      end else if (capture) begin
         wb_valid_q <= 1'b1;
         wb_data_q  <= bus.result_i;
         wb_rd_q    <= rd_q;
      end else if (wb_valid_q && bus.wb_ready_i) begin
         wb_valid_q <= 1'b0;
      end
   end

   generate
      for (genvar i = 0; i < 2; i++) begin : g_imd_reg
         always_ff @(posedge clk_int or negedge rst_ni) begin
            if (!rst_ni)                  imd_q[i] <= 34'd0;
            else if (bus.imd_val_we_i[i]) imd_q[i] <= bus.imd_val_d_i[i];
         end
      end
   endgenerate

   assign bus.req_ready_o        = req_ready;
   assign bus.mult_en_o          = run & is_mul;
   assign bus.mult_sel_o         = run & is_mul;
   assign bus.div_en_o           = run & ~is_mul;
   assign bus.div_sel_o          = run & ~is_mul;
   assign bus.operator_o         = op_q;
   assign bus.signed_mode_o      = signed_q;
   assign bus.op_a_o             = op_a_q;
   assign bus.op_b_o             = op_b_q;
   assign bus.data_ind_timing_o  = DataIndTiming;
   assign bus.multdiv_ready_id_o = ready_id;
   assign bus.imd_val_q_o        = imd_q;
   assign bus.wb_valid_o         = wb_valid_q;
   assign bus.wb_data_o          = wb_data_q;
   assign bus.wb_rd_o            = wb_rd_q;

endmodule
`default_nettype wire

// File: tb/tb_ibex_multdiv_issue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ibex_multdiv_issue : bench with behavioural unit and scoreboard       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_ibex_multdiv_issue;

   localparam logic [1:0] OP_MULL = 2'd0;
   localparam logic [1:0] OP_MULH = 2'd1;
   localparam logic [1:0] OP_DIV  = 2'd2;
   localparam logic [1:0] OP_REM  = 2'd3;

   logic clk_int = 1'b0;
   logic rst_ni  = 1'b1;
   always #5 clk_int = ~clk_int;

   ibex_multdiv_issue_if bus ();

   ibex_multdiv_issue #(.DataIndTiming(1'b0)) dut (
      .clk_int (clk_int),
      .rst_ni  (rst_ni),
      .bus     (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;
   logic chk_on = 1'b0;
   logic sb_en = 1'b0;
   logic rnd_ready = 1'b0;
   int unit_lat = 1;

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // RISC-V M-extension arithmetic from the mode bits {sign_b, sign_a}
   function automatic logic [31:0] ref_md(input logic [1:0] op, input logic [1:0] sg,
                                          input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb, r;
      logic [31:0] res;
      sa = {{32{sg[0] & a[31]}}, a};
      sb = {{32{sg[1] & b[31]}}, b};
      r  = 64'sd0;
      case (op)
         OP_MULL: begin r = sa * sb; res = r[31:0]; end
         OP_MULH: begin r = sa * sb; res = r[63:32]; end
         OP_DIV:  begin
            if (b == 32'd0) res = 32'hFFFF_FFFF;
            else begin r = sa / sb; res = r[31:0]; end
         end
         default: begin
            if (b == 32'd0) res = a;
            else begin r = sa % sb; res = r[31:0]; end
         end
      endcase
      return res;
   endfunction

   // ---------------- behavioural slow unit ----------------
   logic        u_busy;
   int          u_cnt;
   logic [31:0] u_res;
   logic [67:0] u_ops;
   logic        u_run;
   assign u_run        = bus.mult_en_o | bus.div_en_o;
   assign bus.valid_i  = u_busy && (u_cnt == 0);
   assign bus.result_i = u_res;

   always @(posedge clk_int or negedge rst_ni) begin
      if (!rst_ni) begin
         u_busy <= 1'b0;
         u_cnt  <= 0;
         u_res  <= 32'd0;
         u_ops  <= '0;
      end else if (u_busy) begin
         if (u_cnt != 0) u_cnt <= u_cnt - 1;
         else if (bus.multdiv_ready_id_o) u_busy <= 1'b0;
      end else if (u_run) begin
         u_busy <= 1'b1;
         u_cnt  <= unit_lat - 1;
         u_res  <= ref_md(bus.operator_o, bus.signed_mode_o, bus.op_a_o, bus.op_b_o);
         u_ops  <= {bus.operator_o, bus.signed_mode_o, bus.op_a_o, bus.op_b_o};
      end
   end

   always @(negedge clk_int) begin
      if (rst_ni && u_busy) begin
         check("unit_enable_held", u_run, 1'b1);
         check("operands_stable", {bus.operator_o, bus.signed_mode_o, bus.op_a_o, bus.op_b_o}, u_ops);
      end
   end

   // ---------------- intermediate-value registers ----------------
   logic [1:0][33:0] imd_exp;
   initial begin
      bus.imd_val_we_i = 2'b00;
      bus.imd_val_d_i  = '0;
      forever begin
         @(posedge clk_int);
         #1;
         bus.imd_val_we_i = 2'($urandom_range(0, 3));
         bus.imd_val_d_i  = {2'($urandom), 32'($urandom), 2'($urandom), 32'($urandom)};
      end
   end

   always @(posedge clk_int or negedge rst_ni) begin
      if (!rst_ni) imd_exp <= '0;
      else begin
         for (int i = 0; i < 2; i++)
            if (bus.imd_val_we_i[i]) imd_exp[i] <= bus.imd_val_d_i[i];
      end
   end

   always @(negedge clk_int) if (chk_on) check("imd_val_q", bus.imd_val_q_o, imd_exp);

   // ---------------- writeback scoreboard ----------------
   typedef struct { logic [31:0] d; logic [4:0] rd; } exp_t;
   exp_t exp_q[$];

   always @(negedge clk_int) begin : sb
      exp_t e;
      if (sb_en && rst_ni && bus.wb_valid_o && bus.wb_ready_i) begin
         if (exp_q.size() == 0) check("sb_unexpected_result", bus.wb_data_o, 32'd0 - 1);
         else begin
            e = exp_q.pop_front();
            check("sb_data", bus.wb_data_o, e.d);
            check("sb_rd", bus.wb_rd_o, e.rd);
         end
      end
   end

   // ---------------- driver helpers ----------------
   task automatic step();
      @(posedge clk_int);
      #1;
      if (rnd_ready) bus.wb_ready_i = 1'($urandom_range(0, 1));
   endtask

   // returns one cycle after the accepting edge (first BUSY cycle)
   task automatic issue(input logic [1:0] op, input logic [1:0] sg,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
      logic done;
      done = 1'b0;
      bus.req_valid_i  = 1'b1;
      bus.req_op_i     = op;
      bus.req_signed_i = sg;
      bus.req_op_a_i   = a;
      bus.req_op_b_i   = b;
      bus.req_rd_i     = rd;
      for (int k = 0; k < 200 && !done; k++) begin
         @(negedge clk_int);
         done = bus.req_ready_o;
         step();
      end
      bus.req_valid_i = 1'b0;
      if (!done) check("issue_timeout", 1'b0, 1'b1);
      else if (sb_en) exp_q.push_back('{ref_md(op, sg, a, b), rd});
   endtask

   task automatic wait_wb(output int cyc);
      cyc = -1;
      for (int k = 1; k <= 100 && cyc < 0; k++) begin
         @(negedge clk_int);
         if (bus.wb_valid_o) cyc = k;
      end
      if (cyc < 0) check("wb_timeout", 1'b0, 1'b1);
   endtask

   typedef struct {
      logic [1:0]  op;
      logic [1:0]  sg;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] exp;
   } vec_t;
   vec_t tbl[10];

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int cyc;
      logic saw_wb;
      logic [1:0] op, sg;
      logic [31:0] a, b;

      tbl[0] = '{OP_MULL, 2'b11, 32'd7,        32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB};
      tbl[1] = '{OP_DIV,  2'b11, 32'hFFFF_FFF9, 32'd2,        5'd2,  32'hFFFF_FFFD};
      tbl[2] = '{OP_REM,  2'b11, 32'hFFFF_FFF9, 32'd2,        5'd3,  32'hFFFF_FFFF};
      tbl[3] = '{OP_REM,  2'b11, 32'h0000_1234, 32'd0,        5'd4,  32'h0000_1234};
      tbl[4] = '{OP_DIV,  2'b11, 32'd5,         32'd0,        5'd5,  32'hFFFF_FFFF};
      tbl[5] = '{OP_MULH, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE};
      tbl[6] = '{OP_DIV,  2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32'h8000_0000};
      tbl[7] = '{OP_REM,  2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h0000_0000};
      tbl[8] = '{OP_DIV,  2'b00, 32'd100,       32'd7,        5'd31, 32'd14};
      tbl[9] = '{OP_MULH, 2'b11, 32'h8000_0000, 32'd2,        5'd10, 32'hFFFF_FFFF};

      bus.req_valid_i = 1'b1;
      bus.req_op_i = 2'd0; bus.req_signed_i = 2'd0;
      bus.req_op_a_i = 32'd0; bus.req_op_b_i = 32'd0; bus.req_rd_i = 5'd0;
      bus.kill_i = 1'b0;
      bus.wb_ready_i = 1'b0;

      // reset state, with a request already pending
      #2 rst_ni = 1'b0;
      chk_on = 1'b1;
      @(negedge clk_int);
      check("rst_req_ready", bus.req_ready_o, 1'b0);
      check("rst_wb_valid", bus.wb_valid_o, 1'b0);
      check("rst_en_sel", {bus.mult_en_o, bus.div_en_o, bus.mult_sel_o, bus.div_sel_o}, 4'b0);
      check("rst_ready_id", bus.multdiv_ready_id_o, 1'b0);
      check("rst_latched", {bus.operator_o, bus.signed_mode_o, bus.op_a_o, bus.op_b_o}, 68'd0);
      check("rst_wb_data_rd", {bus.wb_data_o, bus.wb_rd_o}, 37'd0);
      check("data_ind_timing", bus.data_ind_timing_o, 1'b0);
      step();
      rst_ni = 1'b1;
      bus.req_valid_i = 1'b0;
      bus.wb_ready_i = 1'b1;
      step();

      // directed vectors, unit latency 1, writeback always ready
      unit_lat = 1;
      for (int i = 0; i < 10; i++) begin
         issue(tbl[i].op, tbl[i].sg, tbl[i].a, tbl[i].b, tbl[i].rd);
         @(negedge clk_int);
         check("vec_mult_en", {bus.mult_en_o, bus.mult_sel_o}, {2{~tbl[i].op[1]}});
         check("vec_div_en", {bus.div_en_o, bus.div_sel_o}, {2{tbl[i].op[1]}});
         check("vec_latched", {bus.operator_o, bus.signed_mode_o, bus.op_a_o, bus.op_b_o},
               {tbl[i].op, tbl[i].sg, tbl[i].a, tbl[i].b});
         wait_wb(cyc);
         check("vec_latency", cyc, 2);
         check("vec_wb_data", bus.wb_data_o, tbl[i].exp);
         check("vec_wb_rd", bus.wb_rd_o, tbl[i].rd);
         @(negedge clk_int);
         check("vec_single_pulse", bus.wb_valid_o, 1'b0);
         step();
      end

      // back-pressure: buffer full while the next result is ready
      bus.wb_ready_i = 1'b0;
      unit_lat = 1;
      issue(OP_MULL, 2'b00, 32'd5, 32'd6, 5'd4);
      wait_wb(cyc);
      check("bp_first", bus.wb_data_o, 32'd30);
      step();
      unit_lat = 3;
      issue(OP_DIV, 2'b00, 32'd1000, 32'd10, 5'd5);
      cyc = 0;
      while (!bus.valid_i && cyc < 20) begin @(negedge clk_int); cyc++; end
      for (int j = 0; j < 3; j++) begin
         if (j > 0) begin step(); @(negedge clk_int); end
         check("bp_ready_id_low", bus.multdiv_ready_id_o, 1'b0);
         check("bp_unit_holds", bus.valid_i, 1'b1);
         check("bp_buffer_kept", {bus.wb_valid_o, bus.wb_data_o}, {1'b1, 32'd30});
      end
      step();
      bus.wb_ready_i = 1'b1;
      @(negedge clk_int);
      check("bp_ready_id_high", bus.multdiv_ready_id_o, 1'b1);
      step();
      @(negedge clk_int);
      check("bp_second", {bus.wb_valid_o, bus.wb_data_o, bus.wb_rd_o}, {1'b1, 32'd100, 5'd5});
      step();
      @(negedge clk_int);
      check("bp_no_duplicate", bus.wb_valid_o, 1'b0);
      step();

      // kill in IDLE blocks acceptance
      bus.kill_i = 1'b1;
      @(negedge clk_int);
      check("idle_kill_ready", bus.req_ready_o, 1'b0);
      step();
      bus.kill_i = 1'b0;

      // kill three cycles into a divide
      unit_lat = 8;
      issue(OP_DIV, 2'b11, 32'd100, 32'd7, 5'd9);
      step();
      step();
      bus.kill_i = 1'b1;
      @(negedge clk_int);
      check("kill_ready_id", bus.multdiv_ready_id_o, 1'b1);
      step();
      bus.kill_i = 1'b0;
      @(negedge clk_int);
      check("drain_div_en", {bus.div_en_o, bus.div_sel_o, bus.req_ready_o}, 3'b110);
      check("drain_ready_id", bus.multdiv_ready_id_o, 1'b1);
      saw_wb = 1'b0;
      cyc = 0;
      while (bus.div_en_o && cyc < 50) begin
         step();
         @(negedge clk_int);
         saw_wb |= bus.wb_valid_o;
         cyc++;
      end
      check("drain_no_wb", saw_wb, 1'b0);
      check("drain_back_idle", {bus.div_en_o, bus.req_ready_o}, 2'b01);
      step();
      unit_lat = 3;
      issue(OP_MULH, 2'b11, 32'h8000_0000, 32'd2, 5'd12);
      wait_wb(cyc);
      check("after_kill_mulh", {bus.wb_data_o, bus.wb_rd_o}, {32'hFFFF_FFFF, 5'd12});
      step();

      // reset in the middle of a MULH
      unit_lat = 8;
      issue(OP_MULH, 2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 5'd17);
      step();
      rst_ni = 1'b0;
      @(negedge clk_int);
      check("midrst_en", {bus.mult_en_o, bus.mult_sel_o, bus.div_en_o, bus.div_sel_o}, 4'b0);
      check("midrst_latched", {bus.operator_o, bus.signed_mode_o, bus.op_a_o, bus.op_b_o}, 68'd0);
      check("midrst_wb", {bus.wb_valid_o, bus.wb_data_o, bus.wb_rd_o}, 38'd0);
      check("midrst_ready", {bus.req_ready_o, bus.multdiv_ready_id_o}, 2'b00);
      step();
      rst_ni = 1'b1;
      step();
      unit_lat = 2;
      issue(OP_MULL, 2'b00, 32'd3, 32'd4, 5'd3);
      wait_wb(cyc);
      check("post_rst_mull", {bus.wb_data_o, bus.wb_rd_o}, {32'd12, 5'd3});
      @(negedge clk_int);
      check("post_rst_pulse", bus.wb_valid_o, 1'b0);
      step();

      // randomized traffic against the scoreboard
      sb_en = 1'b1;
      rnd_ready = 1'b1;
      for (int t = 0; t < 150; t++) begin
         unit_lat = $urandom_range(1, 5);
         op = 2'($urandom_range(0, 3));
         sg = 2'($urandom_range(0, 3));
         a = 32'($urandom);
         b = 32'($urandom);
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = 32'($urandom_range(1, 9));
            default: ;
         endcase
         issue(op, sg, a, b, 5'($urandom));
      end
      rnd_ready = 1'b0;
      bus.wb_ready_i = 1'b1;
      for (int k = 0; k < 20; k++) step();
      check("sb_all_results_seen", exp_q.size(), 0);
      sb_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
